// File: rtl/rgb_frame_writer.sv
// Packs an R,G,B byte stream from uart_rx into RGB444 pixels and writes them
// to the frame RAM with wrapping address, timeout resync, restart and RX LED.
module rgb_frame_writer #(
    parameter int FRAME_W       = 160,
    parameter int FRAME_H       = 120,
    parameter int ADDR_W        = 15,
    parameter int TIMEOUT_CLKS  = 52080,
    parameter int LED_HOLD_CLKS = 2500000
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    input  logic              i_Restart,
    output logic              o_Wr_En,
    output logic [ADDR_W-1:0] o_Wr_Addr,
    output logic [11:0]       o_Wr_Data,
    output logic              o_Frame_Done,
    output logic              o_Sync_Err,
    output logic              o_Busy,
    output logic              o_Rx_Led
);

    localparam int N     = FRAME_W * FRAME_H;
    localparam int TO_W  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int LED_W = $clog2(LED_HOLD_CLKS + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [LED_W-1:0]  LED_LOAD  = LED_W'(LED_HOLD_CLKS);

    typedef enum logic [1:0] {
        S_R,
        S_G,
        S_B
    } state_e;

    state_e            state_q;
    logic [3:0]        r_q;
    logic [3:0]        g_q;
    logic [ADDR_W-1:0] addr_q;
    logic [TO_W-1:0]   to_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [11:0]       wr_data_q;
    logic              done_q;
    logic              err_q;
    logic [LED_W-1:0]  led_q;
    logic [LED_W-1:0]  led_d;
    logic              unused_lo;

    // Only the upper nibble of each colour survives RGB444 packing.
    assign unused_lo = ^i_Rx_Byte[3:0];

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= S_R;
            r_q       <= '0;
            g_q       <= '0;
            addr_q    <= '0;
            to_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (i_Restart) begin
                state_q <= S_R;
                addr_q  <= '0;
                to_q    <= '0;
            end else if (i_Rx_DV) begin
                to_q <= '0;
                unique case (state_q)
                    S_R: begin
                        r_q     <= i_Rx_Byte[7:4];
                        state_q <= S_G;
                    end
                    S_G: begin
                        g_q     <= i_Rx_Byte[7:4];
                        state_q <= S_B;
                    end
                    S_B: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= {r_q, g_q, i_Rx_Byte[7:4]};
                        done_q    <= (addr_q == LAST_ADDR);
                        addr_q    <= (addr_q == LAST_ADDR) ? '0
                                                           : addr_q + ADDR_W'(1);
                        state_q   <= S_R;
                    end
                    default: state_q <= S_R;
                endcase
            end else if (state_q != S_R) begin
                // Stalled mid-pixel: drop the partial pixel once idle too long.
                if (to_q == TO_LAST) begin
                    state_q <= S_R;
                    to_q    <= '0;
                    err_q   <= 1'b1;
                end else begin
                    to_q <= to_q + TO_W'(1);
                end
            end
        end
    end

    always_comb begin
        led_d = led_q;
        if (i_Rx_DV) begin
            led_d = LED_LOAD;
        end else if (led_q != '0) begin
            led_d = led_q - LED_W'(1);
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign o_Wr_En      = wr_en_q;
    assign o_Wr_Addr    = wr_addr_q;
    assign o_Wr_Data    = wr_data_q;
    assign o_Frame_Done = done_q;
    assign o_Sync_Err   = err_q;
    assign o_Busy       = (state_q != S_R);
    assign o_Rx_Led     = (led_q != '0);

endmodule
